// File: rtl/rope_pkg.sv
// Shared types and fixed-point constants for the rope scheduler.
package rope_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MOVE  = 2'd1,
    S_SPAWN = 2'd2
  } state_t;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int XFP_W                  = 17;
  localparam int IDX_W                  = 2;

endpackage

// File: rtl/rope_free_slot_finder.sv
// Priority encoder: reports the lowest-index slot whose active bit is clear.
module rope_free_slot_finder
  import rope_pkg::*;
(
  input  logic [3:0]       i_active,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!i_active[i]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rope_scheduler.sv
// Per-frame rope slot scheduler: moves active ropes one slot per cycle, retires
// them past the right edge, and spawns a new rope every SPAWN_PERIOD frames.
module rope_scheduler
  import rope_pkg::*;
#(
  parameter int NUM_ROPES    = 4,
  parameter int X_SPEED      = 30,
  parameter int X_START      = 0,
  parameter int X_LIMIT      = 640,
  parameter int Y_BASE       = 100,
  parameter int Y_STEP       = 80,
  parameter int SPAWN_PERIOD = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 pause,
  input  logic                 kill_valid,
  input  logic [IDX_W-1:0]     kill_idx,
  output logic signed [10:0]   topLeftX [NUM_ROPES],
  output logic signed [10:0]   topLeftY [NUM_ROPES],
  output logic [NUM_ROPES-1:0] rope_active,
  output logic                 spawn_pulse,
  output logic                 busy
);

  localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [XFP_W-1:0] XFP_START  = XFP_W'(X_START * FIXED_POINT_MULTIPLIER);
  localparam logic [XFP_W:0]   XFP_LIMIT  = (XFP_W + 1)'(X_LIMIT * FIXED_POINT_MULTIPLIER);
  localparam logic [XFP_W:0]   XFP_SPEED  = (XFP_W + 1)'(X_SPEED);
  localparam logic [IDX_W-1:0] SLOT_LAST  = IDX_W'(NUM_ROPES - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [IDX_W-1:0]       r_slot;
  logic [XFP_W-1:0]       r_xfp [NUM_ROPES];
  logic [NUM_ROPES-1:0]   r_active;
  logic [CNT_W-1:0]       r_frame_cnt;

  logic                   w_free_valid;
  logic [IDX_W-1:0]       w_free_idx;
  logic [XFP_W:0]         w_moved;
  logic                   w_kill_move;
  logic                   w_spawn_due;
  logic                   w_spawn_ok;

  rope_free_slot_finder u_finder (
    .i_active (r_active),
    .o_valid  (w_free_valid),
    .o_idx    (w_free_idx)
  );

  // One extra bit on the sum so the retire compare cannot wrap.
  assign w_moved     = {1'b0, r_xfp[r_slot]} + XFP_SPEED;
  assign w_kill_move = kill_valid && (kill_idx == r_slot);
  assign w_spawn_due = (r_state == S_SPAWN) && (r_frame_cnt == CNT_LAST);
  assign w_spawn_ok  = w_spawn_due && w_free_valid &&
                       !(kill_valid && (kill_idx == w_free_idx));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (startOfFrame && !pause) w_next = S_MOVE;
      S_MOVE:  if (r_slot == SLOT_LAST) w_next = S_SPAWN;
      S_SPAWN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot      <= '0;
      r_active    <= '0;
      r_frame_cnt <= '0;
      for (int i = 0; i < NUM_ROPES; i++) r_xfp[i] <= '0;
    end else begin
      if (r_state == S_MOVE) r_slot <= r_slot + 1'b1;
      else                   r_slot <= '0;

      if ((r_state == S_MOVE) && r_active[r_slot] && !w_kill_move) begin
        if (w_moved >= XFP_LIMIT) begin
          r_active[r_slot] <= 1'b0;
          r_xfp[r_slot]    <= XFP_START;
        end else begin
          r_xfp[r_slot]    <= w_moved[XFP_W-1:0];
        end
      end

      if (r_state == S_SPAWN) begin
        if (r_frame_cnt == CNT_LAST) r_frame_cnt <= '0;
        else                         r_frame_cnt <= r_frame_cnt + 1'b1;
        if (w_spawn_ok) begin
          r_active[w_free_idx] <= 1'b1;
          r_xfp[w_free_idx]    <= XFP_START;
        end
      end

      // Placed last so a kill overrides any move or spawn on the same slot.
      if (kill_valid) r_active[kill_idx] <= 1'b0;
    end
  end

  assign rope_active = r_active;
  assign spawn_pulse = w_spawn_ok;
  assign busy        = (r_state != S_IDLE);

  for (genvar g = 0; g < NUM_ROPES; g++) begin : g_pos
    assign topLeftX[g] = $signed(r_xfp[g][XFP_W-1:6]);
    assign topLeftY[g] = $signed(11'(Y_BASE + g * Y_STEP));
  end

endmodule
